// File: rtl/prbs31_pkg.sv
// Shared PRBS31 (x^31 + x^28 + 1) definitions for the byte-stream link.
// Used by both the byte generator and the byte checker.
//   - tap positions
//   - checker FSM state encodings (SEED=0, VERIFY=1, LOCKED=2)
//   - prbs31_next8: advances the LFSR by 8 steps, returns {next_state, byte}
//   - popcount8: number of set bits in a byte (0..8)
package prbs31_pkg;

  localparam int unsigned PrbsLen = 31;
  localparam int unsigned TapHi   = 31;
  localparam int unsigned TapLo   = 28;

  // Checker FSM encodings; the two LSBs are exported on the status byte.
  localparam logic [1:0] StSeed   = 2'd0;
  localparam logic [1:0] StVerify = 2'd1;
  localparam logic [1:0] StLocked = 2'd2;

  // Eight LFSR steps. The first generated bit lands in byte[7].
  function automatic logic [PrbsLen+7:0] prbs31_next8(input logic [PrbsLen-1:0] s);
    logic [PrbsLen-1:0] st;
    logic [7:0]         b;
    logic               nb;
    st = s;
    b  = '0;
    for (int i = 0; i < 8; i++) begin
      nb       = st[TapHi-1] ^ st[TapLo-1];
      st       = {st[PrbsLen-2:0], nb};
      b[7-i]   = nb;
    end
    return {st, b};
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/prbs31_byte_predict.sv
// Combinational PRBS31 byte predictor.
// Ports:
//   state_i      - current 31-bit LFSR state
//   pred_byte_o  - next 8 sequence bits, earliest bit in [7]
//   state_next_o - LFSR state after those 8 steps
module prbs31_byte_predict (
  input  logic [30:0] state_i,
  output logic [7:0]  pred_byte_o,
  output logic [30:0] state_next_o
);
  import prbs31_pkg::*;

  always_comb begin
    {state_next_o, pred_byte_o} = prbs31_next8(state_i);
  end

endmodule

// File: rtl/prbs31_byte_checker.sv
// PRBS31 byte-stream receive checker.
// Self-synchronises to an incoming PRBS31 byte stream (SEED), confirms a run of correctly
// predicted bytes (VERIFY), then free-runs its own predictor and counts bit errors (LOCKED).
// Ports:
//   clk      - clock
//   rst_n    - asynchronous reset, active-high (legacy name)
//   ena      - design enable; when low all state holds and valid is ignored
//   ui_in    - received byte, ui_in[7] earliest in sequence order
//   uio_in   - [0] valid, [1] clear counters, [2] snapshot, [4:3] read select
//   uo_out   - read mux: sel 0/1/2 snapshot bytes, sel 3 status byte
//   uio_out  - [7] locked, [6] lock_lost, [5] err_this_byte, [4] sat
//   uio_oe   - constant 8'hF0
module prbs31_byte_checker #(
  parameter int unsigned LOCK_BYTES = 4,
  parameter int unsigned LOSS_BYTES = 4,
  parameter int unsigned CNT_W      = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  import prbs31_pkg::*;

  localparam int unsigned GoodW = $clog2(LOCK_BYTES + 1);
  localparam int unsigned BadW  = $clog2(LOSS_BYTES + 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  // Control decode; ena gates every state-changing request.
  logic       accept, clr_req, snap_req;
  logic [1:0] rd_sel;
  logic       unused_uio;

  assign accept     = ena & uio_in[0];
  assign clr_req    = ena & uio_in[1];
  assign snap_req   = ena & uio_in[2];
  assign rd_sel     = uio_in[4:3];
  assign unused_uio = ^uio_in[7:5];

  // State
  logic [1:0]       state_q, state_d;
  logic [30:0]      s_q, s_d;
  logic [1:0]       seed_cnt_q, seed_cnt_d;
  logic [GoodW-1:0] good_cnt_q, good_cnt_d;
  logic [BadW-1:0]  bad_run_q, bad_run_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [23:0]      snap_q, snap_d;
  logic             sat_q, sat_d;
  logic             lock_lost_q, lock_lost_d;
  logic             err_byte_q, err_byte_d;

  // Prediction
  logic [7:0]  pred_byte;
  logic [30:0] pred_state;
  logic [30:0] rx_state;
  logic [3:0]  err_bits;
  logic [CNT_W:0] err_sum;
  logic        locked;

  prbs31_byte_predict u_predict (
    .state_i      (s_q),
    .pred_byte_o  (pred_byte),
    .state_next_o (pred_state)
  );

  // Received bits shifted into the state, earliest bit first.
  assign rx_state = {s_q[22:0], ui_in};
  assign err_bits = popcount8(pred_byte ^ ui_in);
  assign err_sum  = {1'b0, err_cnt_q} + (CNT_W + 1)'(err_bits);
  assign locked   = (state_q == StLocked);

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    seed_cnt_d  = seed_cnt_q;
    good_cnt_d  = good_cnt_q;
    bad_run_d   = bad_run_q;
    err_cnt_d   = err_cnt_q;
    snap_d      = snap_q;
    sat_d       = sat_q;
    lock_lost_d = lock_lost_q;
    err_byte_d  = 1'b0;

    if (accept) begin
      case (state_q)
        StSeed: begin
          s_d = rx_state;
          if (seed_cnt_q == 2'd3) begin
            seed_cnt_d = '0;
            // An all-zero state is the LFSR lockup point; keep seeding.
            if (rx_state != '0) begin
              state_d    = StVerify;
              good_cnt_d = '0;
            end
          end else begin
            seed_cnt_d = seed_cnt_q + 2'd1;
          end
        end

        StVerify: begin
          // Still self-synchronising: the state follows the received bits.
          s_d = rx_state;
          if (pred_byte == ui_in) begin
            if ((32'(good_cnt_q) + 32'd1) >= LOCK_BYTES) begin
              state_d    = StLocked;
              good_cnt_d = '0;
              bad_run_d  = '0;
            end else begin
              good_cnt_d = good_cnt_q + GoodW'(1);
            end
          end else begin
            state_d    = StSeed;
            good_cnt_d = '0;
            seed_cnt_d = '0;
          end
        end

        StLocked: begin
          // Free-run on the prediction so line errors do not corrupt the state.
          s_d        = pred_state;
          err_byte_d = (err_bits != 4'd0);
          if (err_sum >= {1'b0, CntMax}) begin
            err_cnt_d = CntMax;
            sat_d     = 1'b1;
          end else begin
            err_cnt_d = err_sum[CNT_W-1:0];
          end
          if (err_bits != 4'd0) begin
            if ((32'(bad_run_q) + 32'd1) >= LOSS_BYTES) begin
              state_d     = StSeed;
              seed_cnt_d  = '0;
              bad_run_d   = '0;
              lock_lost_d = 1'b1;
            end else begin
              bad_run_d = bad_run_q + BadW'(1);
            end
          end else begin
            bad_run_d = '0;
          end
        end

        default: begin
          state_d    = StSeed;
          seed_cnt_d = '0;
        end
      endcase
    end

    // Snapshot takes the pre-update count; clear overrides both.
    if (snap_req) begin
      snap_d = 24'(err_cnt_q);
    end
    if (clr_req) begin
      err_cnt_d   = '0;
      snap_d      = '0;
      sat_d       = 1'b0;
      lock_lost_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= StSeed;
      s_q         <= '0;
      seed_cnt_q  <= '0;
      good_cnt_q  <= '0;
      bad_run_q   <= '0;
      err_cnt_q   <= '0;
      snap_q      <= '0;
      sat_q       <= 1'b0;
      lock_lost_q <= 1'b0;
      err_byte_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      seed_cnt_q  <= seed_cnt_d;
      good_cnt_q  <= good_cnt_d;
      bad_run_q   <= bad_run_d;
      err_cnt_q   <= err_cnt_d;
      snap_q      <= snap_d;
      sat_q       <= sat_d;
      lock_lost_q <= lock_lost_d;
      err_byte_q  <= err_byte_d;
    end
  end

  always_comb begin
    uo_out = 8'h00;
    case (rd_sel)
      2'd0:    uo_out = snap_q[7:0];
      2'd1:    uo_out = snap_q[15:8];
      2'd2:    uo_out = snap_q[23:16];
      default: uo_out = {locked, lock_lost_q, sat_q, state_q, 3'b000};
    endcase
  end

  assign uio_out = {locked, lock_lost_q, err_byte_q, sat_q, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_prbs31_byte_checker.sv
module tb_prbs31_byte_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic       valid = 1'b0, clr = 1'b0, snap = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [7:0] uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [7:0] uo_out_s, uio_out_s, uio_oe_s;

  int total = 0;
  int bad = 0;

  logic [30:0] gen_s;

  assign uio_in = {3'b000, sel, snap, clr, valid};

  always #5 clk = ~clk;

  prbs31_byte_checker dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  prbs31_byte_checker #(.CNT_W(4)) dut_sat (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out_s),
    .uio_out (uio_out_s),
    .uio_oe  (uio_oe_s)
  );

  // Generator reference: b = S[30]^S[27], S <= {S[29:0], b}, first bit to [7].
  task automatic gen_byte(output logic [7:0] b);
    logic nb;
    for (int i = 0; i < 8; i++) begin
      nb       = gen_s[30] ^ gen_s[27];
      gen_s    = {gen_s[29:0], nb};
      b[7-i]   = nb;
    end
  endtask

  task automatic step(input logic [7:0] b, input logic v, input logic c, input logic s);
    ui_in = b; valid = v; clr = c; snap = s;
    @(posedge clk); #1;
    valid = 1'b0; clr = 1'b0; snap = 1'b0;
  endtask

  task automatic send_gen(input logic [7:0] mask, input logic c, input logic s);
    logic [7:0] b;
    gen_byte(b);
    step(b ^ mask, 1'b1, c, s);
  endtask

  // Snapshot then read the 24-bit count from one instance.
  task automatic read_err(input logic main, output logic [23:0] v);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    sel = 2'd0; #1 v[7:0]   = main ? uo_out : uo_out_s;
    sel = 2'd1; #1 v[15:8]  = main ? uo_out : uo_out_s;
    sel = 2'd2; #1 v[23:16] = main ? uo_out : uo_out_s;
    sel = 2'd0;
  endtask

  task automatic get_status(output logic [7:0] st);
    sel = 2'd3; #1 st = uo_out; sel = 2'd0;
  endtask

  task automatic test_reset;
    logic [7:0] st;
    rst_n = 1'b1;
    #22 rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if (uo_out !== 8'h00) begin bad++; $display("FAIL reset_uo_out: got %h want 00", uo_out); end
    total++; if (uio_out !== 8'h00) begin bad++; $display("FAIL reset_uio_out: got %h want 00", uio_out); end
    total++; if (uio_oe !== 8'hF0) begin bad++; $display("FAIL reset_uio_oe: got %h want f0", uio_oe); end
    get_status(st);
    total++; if (st !== 8'h00) begin bad++; $display("FAIL reset_status: got %h want 00", st); end
  endtask

  task automatic test_seed_lock;
    logic [7:0]  st;
    logic [23:0] e;
    gen_s = 31'h7FFF_FFFF;
    for (int i = 1; i <= 8; i++) begin
      send_gen(8'h00, 1'b0, 1'b0);
      get_status(st);
      if (i == 3 || i == 4) begin
        total++;
        if (st[4:3] !== ((i == 4) ? 2'd1 : 2'd0)) begin
          bad++; $display("FAIL seed_fsm byte %0d: got %0d want %0d", i, st[4:3], (i == 4) ? 1 : 0);
        end
      end
      if (i >= 7) begin
        total++;
        if (uio_out[7] !== (i == 8)) begin
          bad++; $display("FAIL seed_locked byte %0d: got %b want %b", i, uio_out[7], i == 8);
        end
      end
    end
    read_err(1'b1, e);
    total++; if (e !== 24'd0) begin bad++; $display("FAIL seed_err: got %0d want 0", e); end
  endtask

  task automatic test_errors;
    logic [7:0]  m;
    logic [23:0] e;
    for (int i = 9; i <= 30; i++) begin
      m = (i == 20) ? 8'h01 : ((i == 25) ? 8'hFF : 8'h00);
      send_gen(m, 1'b0, 1'b0);
      total++;
      if (uio_out[5] !== (m != 8'h00)) begin
        bad++; $display("FAIL err_this_byte byte %0d: got %b want %b", i, uio_out[5], m != 8'h00);
      end
    end
    total++; if (uio_out[7] !== 1'b1) begin bad++; $display("FAIL errors_locked: got %b want 1", uio_out[7]); end
    read_err(1'b1, e);
    total++; if (e !== 24'd9) begin bad++; $display("FAIL errors_cnt: got %0d want 9", e); end
  endtask

  task automatic test_loss;
    logic [7:0]  st;
    logic [23:0] e;
    for (int k = 0; k < 4; k++) begin
      send_gen(8'h10, 1'b0, 1'b0);
      total++;
      if (uio_out[7] !== (k < 3)) begin
        bad++; $display("FAIL loss_locked corrupt %0d: got %b want %b", k, uio_out[7], k < 3);
      end
    end
    get_status(st);
    total++; if (st[6] !== 1'b1) begin bad++; $display("FAIL loss_lost: got %b want 1", st[6]); end
    total++; if (st[4:3] !== 2'd0) begin bad++; $display("FAIL loss_fsm: got %0d want 0", st[4:3]); end
    read_err(1'b1, e);
    total++; if (e !== 24'd13) begin bad++; $display("FAIL loss_cnt: got %0d want 13", e); end
    for (int i = 1; i <= 8; i++) begin
      send_gen(8'h00, 1'b0, 1'b0);
      if (i >= 7) begin
        total++;
        if (uio_out[7] !== (i == 8)) begin
          bad++; $display("FAIL relock byte %0d: got %b want %b", i, uio_out[7], i == 8);
        end
      end
    end
    total++; if (uio_out[6] !== 1'b1) begin bad++; $display("FAIL relock_sticky: got %b want 1", uio_out[6]); end
    step(8'h00, 1'b0, 1'b1, 1'b0);
    total++; if (uio_out[6] !== 1'b0) begin bad++; $display("FAIL clear_lost: got %b want 0", uio_out[6]); end
    read_err(1'b1, e);
    total++; if (e !== 24'd0) begin bad++; $display("FAIL clear_cnt: got %0d want 0", e); end
  endtask

  task automatic test_sat;
    logic [23:0] e;
    for (int k = 0; k < 3; k++) send_gen(8'hFF, 1'b0, 1'b0);
    send_gen(8'h00, 1'b0, 1'b0);
    read_err(1'b1, e);
    total++; if (e !== 24'd24) begin bad++; $display("FAIL sat_main_cnt: got %0d want 24", e); end
    total++; if (uio_out[4] !== 1'b0) begin bad++; $display("FAIL sat_main_flag: got %b want 0", uio_out[4]); end
    read_err(1'b0, e);
    total++; if (e !== 24'd15) begin bad++; $display("FAIL sat_small_cnt: got %0d want 15", e); end
    total++; if (uio_out_s[4] !== 1'b1) begin bad++; $display("FAIL sat_small_flag: got %b want 1", uio_out_s[4]); end
    total++; if (uio_out_s[7] !== 1'b1) begin bad++; $display("FAIL sat_small_locked: got %b want 1", uio_out_s[7]); end
    // Clear alongside an errored byte discards that byte's errors.
    send_gen(8'hFF, 1'b1, 1'b0);
    total++; if (uio_out_s[4] !== 1'b0) begin bad++; $display("FAIL clr_sat_flag: got %b want 0", uio_out_s[4]); end
    read_err(1'b0, e);
    total++; if (e !== 24'd0) begin bad++; $display("FAIL clr_small_cnt: got %0d want 0", e); end
    read_err(1'b1, e);
    total++; if (e !== 24'd0) begin bad++; $display("FAIL clr_main_cnt: got %0d want 0", e); end
    send_gen(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_snapshot;
    logic [23:0] e;
    send_gen(8'h03, 1'b0, 1'b1);
    #1;
    total++; if (uo_out !== 8'h00) begin bad++; $display("FAIL snap_preupdate: got %h want 00", uo_out); end
    read_err(1'b1, e);
    total++; if (e !== 24'd2) begin bad++; $display("FAIL snap_post: got %0d want 2", e); end
    send_gen(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_ena_hold;
    logic [7:0]  st0, st1, u0;
    logic [23:0] e;
    get_status(st0);
    u0 = uio_out;
    ena = 1'b0;
    for (int i = 0; i < 10; i++) step(8'(i * 37 + 5), 1'b1, 1'b0, 1'b0);
    get_status(st1);
    ena = 1'b1;
    total++; if (st1 !== st0) begin bad++; $display("FAIL ena_status: got %h want %h", st1, st0); end
    total++; if (uio_out !== u0) begin bad++; $display("FAIL ena_uio: got %h want %h", uio_out, u0); end
    send_gen(8'h00, 1'b0, 1'b0);
    total++; if (uio_out !== 8'h80) begin bad++; $display("FAIL ena_resume: got %h want 80", uio_out); end
    read_err(1'b1, e);
    total++; if (e !== 24'd2) begin bad++; $display("FAIL ena_cnt: got %0d want 2", e); end
  endtask

  task automatic test_reset_mid;
    logic [23:0] e;
    logic [7:0]  st;
    send_gen(8'h01, 1'b0, 1'b0);
    read_err(1'b1, e);
    total++; if (e !== 24'd3) begin bad++; $display("FAIL midrst_pre: got %0d want 3", e); end
    #1 rst_n = 1'b1;
    #1;
    total++; if (uo_out !== 8'h00) begin bad++; $display("FAIL midrst_uo: got %h want 00", uo_out); end
    total++; if (uio_out !== 8'h00) begin bad++; $display("FAIL midrst_uio: got %h want 00", uio_out); end
    total++; if (uio_out_s !== 8'h00) begin bad++; $display("FAIL midrst_uio_s: got %h want 00", uio_out_s); end
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    for (int i = 1; i <= 8; i++) begin
      send_gen(8'h00, 1'b0, 1'b0);
      if (i == 3 || i == 4) begin
        get_status(st);
        total++;
        if (st[4:3] !== ((i == 4) ? 2'd1 : 2'd0)) begin
          bad++; $display("FAIL midrst_fsm byte %0d: got %0d want %0d", i, st[4:3], (i == 4) ? 1 : 0);
        end
      end
    end
    total++; if (uio_out[7] !== 1'b1) begin bad++; $display("FAIL midrst_relock: got %b want 1", uio_out[7]); end
  endtask

  task automatic test_zero_and_mismatch;
    logic [7:0]  st;
    logic [23:0] e;
    #1 rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    for (int i = 1; i <= 12; i++) begin
      step(8'h00, 1'b1, 1'b0, 1'b0);
      if (i % 4 == 0) begin
        get_status(st);
        total++; if (st[4:3] !== 2'd0) begin bad++; $display("FAIL zero_fsm byte %0d: got %0d want 0", i, st[4:3]); end
      end
    end
    read_err(1'b1, e);
    total++; if (e !== 24'd0) begin bad++; $display("FAIL zero_cnt: got %0d want 0", e); end
    for (int i = 0; i < 4; i++) send_gen(8'h00, 1'b0, 1'b0);
    get_status(st);
    total++; if (st[4:3] !== 2'd1) begin bad++; $display("FAIL mm_verify: got %0d want 1", st[4:3]); end
    send_gen(8'h40, 1'b0, 1'b0);
    get_status(st);
    total++; if (st[4:3] !== 2'd0) begin bad++; $display("FAIL mm_seed: got %0d want 0", st[4:3]); end
    total++; if (st[7] !== 1'b0) begin bad++; $display("FAIL mm_locked: got %b want 0", st[7]); end
  endtask

  initial begin
    test_reset();
    test_seed_lock();
    test_errors();
    test_loss();
    test_sat();
    test_snapshot();
    test_ena_hold();
    test_reset_mid();
    test_zero_and_mismatch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
